// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter states: which transaction (if any) owns the external port.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

    // Starvation counter width; holds limits up to 15.
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating counter with clear, used to count data grants won while fetch waits.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_W = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch and
// data access. Data normally wins; fetch is forced ahead once it has lost
// STARVE_LIMIT data grants in a row. Cancelled fetches are drained silently.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req,
    input  logic [ADDR_WIDTH-1:0]   fetch_addr,
    input  logic                    fetch_cancel,
    output logic [DATA_WIDTH-1:0]   fetch_rdata,
    output logic                    fetch_done,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_done,
    output logic                    ext_req,
    output logic                    ext_we,
    output logic [DATA_WIDTH/8-1:0] ext_be,
    output logic [ADDR_WIDTH-1:0]   ext_addr,
    output logic [DATA_WIDTH-1:0]   ext_wdata,
    input  logic [DATA_WIDTH-1:0]   ext_rdata,
    input  logic                    ext_ready,
    output logic                    busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;

    logic                  ext_we_q,    ext_we_d;
    logic [BE_WIDTH-1:0]   ext_be_q,    ext_be_d;
    logic [ADDR_WIDTH-1:0] ext_addr_q,  ext_addr_d;
    logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;
    logic [DATA_WIDTH-1:0] fetch_rdata_q, fetch_rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q,   mem_rdata_d;

    logic complete;
    logic arb_en;
    logic fetch_elig;
    logic data_elig;
    logic grant_fetch;
    logic grant_data;
    logic fetch_done_c;
    logic data_done_c;
    logic mem_read_done_c;
    logic starve_at_limit;
    logic starve_inc;
    logic starve_clr;

    // Completion, eligibility and grant decisions. A port whose access just
    // completed is masked because its request still reflects that access.
    // In DRAIN the fetch port is only masked by fetch_cancel itself.
    always_comb begin
        complete        = ext_ready && (state_q != ARB_IDLE);
        arb_en          = (state_q == ARB_IDLE) || complete;
        fetch_elig      = fetch_req && !fetch_cancel
                          && !(complete && (state_q == ARB_FETCH));
        data_elig       = mem_req && !(complete && (state_q == ARB_DATA));
        grant_fetch     = arb_en && fetch_elig && (!data_elig || starve_at_limit);
        grant_data      = arb_en && data_elig && !(fetch_elig && starve_at_limit);
        fetch_done_c    = complete && (state_q == ARB_FETCH) && !fetch_cancel;
        data_done_c     = complete && (state_q == ARB_DATA);
        mem_read_done_c = data_done_c && !ext_we_q;
        starve_inc      = grant_data && fetch_req && !fetch_cancel;
        starve_clr      = grant_fetch || !fetch_req;
    end

    // Next state and next external request fields.
    always_comb begin
        state_d       = state_q;
        ext_we_d      = ext_we_q;
        ext_be_d      = ext_be_q;
        ext_addr_d    = ext_addr_q;
        ext_wdata_d   = ext_wdata_q;
        fetch_rdata_d = fetch_rdata_q;
        mem_rdata_d   = mem_rdata_q;

        if (fetch_done_c) begin
            fetch_rdata_d = ext_rdata;
        end
        if (mem_read_done_c) begin
            mem_rdata_d = ext_rdata;
        end

        if (grant_fetch) begin
            state_d    = ARB_FETCH;
            ext_we_d   = 1'b0;
            ext_be_d   = '1;
            ext_addr_d = fetch_addr;
        end else if (grant_data) begin
            state_d     = ARB_DATA;
            ext_we_d    = mem_we;
            ext_be_d    = mem_be;
            ext_addr_d  = mem_addr;
            ext_wdata_d = mem_wdata;
        end else if (complete) begin
            state_d = ARB_IDLE;
        end else if ((state_q == ARB_FETCH) && fetch_cancel) begin
            state_d = ARB_DRAIN;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            ext_we_q      <= 1'b0;
            ext_be_q      <= '0;
            ext_addr_q    <= '0;
            ext_wdata_q   <= '0;
            fetch_rdata_q <= '0;
            mem_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            ext_we_q      <= ext_we_d;
            ext_be_q      <= ext_be_d;
            ext_addr_q    <= ext_addr_d;
            ext_wdata_q   <= ext_wdata_d;
            fetch_rdata_q <= fetch_rdata_d;
            mem_rdata_q   <= mem_rdata_d;
        end
    end

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (starve_clr),
        .inc_i      (starve_inc),
        .at_limit_o (starve_at_limit)
    );

    // The external request is outstanding whenever the arbiter is not idle,
    // so it drops together with the state on reset.
    assign ext_req     = (state_q != ARB_IDLE);
    assign busy        = (state_q != ARB_IDLE);
    assign ext_we      = ext_we_q;
    assign ext_be      = ext_be_q;
    assign ext_addr    = ext_addr_q;
    assign ext_wdata   = ext_wdata_q;
    assign fetch_done  = fetch_done_c;
    assign mem_done    = !mem_req || data_done_c;
    assign fetch_rdata = fetch_done_c ? ext_rdata : fetch_rdata_q;
    assign mem_rdata   = mem_read_done_c ? ext_rdata : mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_cancel = 1'b0;
    logic [DW-1:0] fetch_rdata;
    logic          fetch_done;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [3:0]    mem_be = 4'h0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          ext_req;
    logic          ext_we;
    logic [3:0]    ext_be;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata = '0;
    logic          ext_ready = 1'b0;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    mem_port_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_cancel (fetch_cancel),
        .fetch_rdata  (fetch_rdata),
        .fetch_done   (fetch_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .ext_req      (ext_req),
        .ext_we       (ext_we),
        .ext_be       (ext_be),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_rdata    (ext_rdata),
        .ext_ready    (ext_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 fetch, 2 data), whether
    // the owning fetch was cancelled, how many grants fetch has lost, the
    // request fields presented externally and the last returned words.
    int            m_owner = 0;
    bit            m_dropped = 1'b0;
    int            m_waits = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0;
    logic [3:0]    m_be = 4'h0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_held_f = '0;
    logic [DW-1:0] m_held_m = '0;

    int            n_owner;
    bit            n_dropped;
    int            n_waits;
    logic [AW-1:0] n_addr;
    logic          n_we;
    logic [3:0]    n_be;
    logic [DW-1:0] n_wdata;
    logic [DW-1:0] n_held_f;
    logic [DW-1:0] n_held_m;

    // Compare every cycle at the falling edge and work out the model's next step.
    initial begin
        bit done_now, e_fdone, e_mdone, f_ok, d_ok, pick_f, pick_d;
        logic [DW-1:0] e_frd, e_mrd;
        forever begin
            @(negedge clk);
            if (model_on) begin
                done_now = (m_owner != 0) && ext_ready;
                e_fdone  = done_now && (m_owner == 1) && !m_dropped && !fetch_cancel;
                e_mdone  = !mem_req || (done_now && (m_owner == 2));
                e_frd    = e_fdone ? ext_rdata : m_held_f;
                e_mrd    = (done_now && (m_owner == 2) && !m_we) ? ext_rdata : m_held_m;

                check("model_fetch_done", fetch_done, e_fdone);
                check("model_mem_done", mem_done, e_mdone);
                check("model_fetch_rdata", fetch_rdata, e_frd);
                check("model_mem_rdata", mem_rdata, e_mrd);
                check("model_ext_req", ext_req, m_owner != 0);
                check("model_busy", busy, m_owner != 0);
                if (m_owner != 0) begin
                    check("model_ext_addr", ext_addr, m_addr);
                    check("model_ext_we", ext_we, m_we);
                    check("model_ext_be", ext_be, m_be);
                end
                if (m_owner == 2) begin
                    check("model_ext_wdata", ext_wdata, m_wdata);
                end

                n_owner   = m_owner;
                n_dropped = m_dropped;
                n_waits   = m_waits;
                n_addr    = m_addr;
                n_we      = m_we;
                n_be      = m_be;
                n_wdata   = m_wdata;
                n_held_f  = e_frd;
                n_held_m  = e_mrd;
                pick_f    = 1'b0;
                pick_d    = 1'b0;

                if ((m_owner == 1) && !m_dropped && fetch_cancel && !ext_ready) begin
                    n_dropped = 1'b1;
                end
                if ((m_owner == 0) || done_now) begin
                    f_ok   = fetch_req && !fetch_cancel && !(done_now && (m_owner == 1) && !m_dropped);
                    d_ok   = mem_req && !(done_now && (m_owner == 2));
                    pick_f = f_ok && (!d_ok || (m_waits >= LIMIT));
                    pick_d = d_ok && !pick_f;
                    n_owner   = pick_f ? 1 : (pick_d ? 2 : 0);
                    n_dropped = 1'b0;
                    if (pick_f) begin
                        n_addr = fetch_addr;
                        n_we   = 1'b0;
                        n_be   = 4'hF;
                    end
                    if (pick_d) begin
                        n_addr  = mem_addr;
                        n_we    = mem_we;
                        n_be    = mem_be;
                        n_wdata = mem_wdata;
                    end
                end
                if (!fetch_req || pick_f) begin
                    n_waits = 0;
                end else if (pick_d && !fetch_cancel) begin
                    n_waits = (m_waits + 1 > LIMIT) ? LIMIT : m_waits + 1;
                end
            end
        end
    end

    // Commit the model step on the rising edge; reset clears it at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner   <= 0;
            m_dropped <= 1'b0;
            m_waits   <= 0;
            m_addr    <= '0;
            m_we      <= 1'b0;
            m_be      <= 4'h0;
            m_wdata   <= '0;
            m_held_f  <= '0;
            m_held_m  <= '0;
        end else if (model_on) begin
            m_owner   <= n_owner;
            m_dropped <= n_dropped;
            m_waits   <= n_waits;
            m_addr    <= n_addr;
            m_we      <= n_we;
            m_be      <= n_be;
            m_wdata   <= n_wdata;
            m_held_f  <= n_held_f;
            m_held_m  <= n_held_m;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fetch_req    = 1'b0;
        fetch_cancel = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ext_ready    = 1'b0;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        #1 rst = 1'b1;
        model_on = 1'b1;
        tick;
        tick;
        check("reset_ext_req", ext_req, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_mem_done", mem_done, 1'b1);
        check("reset_fetch_rdata", fetch_rdata, 32'h0);
        check("reset_ext_addr", ext_addr, 32'h0);
        rst = 1'b0;
        tick;

        // Single fetch, ready in cycle 3.
        fetch_req = 1'b1; fetch_addr = 32'h100;
        tick;
        #1 check("fetch_ext_req", ext_req, 1'b1);
        check("fetch_ext_addr", ext_addr, 32'h100);
        check("fetch_ext_be", ext_be, 4'hF);
        check("fetch_ext_we", ext_we, 1'b0);
        tick;
        tick;
        ext_ready = 1'b1; ext_rdata = 32'h2402000A;
        #1 check("fetch_done_pulse", fetch_done, 1'b1);
        check("fetch_rdata_live", fetch_rdata, 32'h2402000A);
        tick;
        idle_inputs;
        #1 check("fetch_idle_after", ext_req, 1'b0);
        check("fetch_rdata_held", fetch_rdata, 32'h2402000A);
        tick;

        // Simultaneous: data write first, fetch back-to-back.
        fetch_req = 1'b1; fetch_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; mem_be = 4'hF;
        tick;
        #1 check("simul_data_we", ext_we, 1'b1);
        check("simul_data_addr", ext_addr, 32'h200);
        check("simul_data_wdata", ext_wdata, 32'hDEADBEEF);
        check("simul_mem_done_wait", mem_done, 1'b0);
        ext_ready = 1'b1; ext_rdata = 32'h0;
        #1 check("simul_mem_done", mem_done, 1'b1);
        tick;
        mem_req = 1'b0; mem_we = 1'b0; ext_ready = 1'b0;
        #1 check("simul_fetch_b2b_req", ext_req, 1'b1);
        check("simul_fetch_b2b_addr", ext_addr, 32'h104);
        check("simul_fetch_b2b_we", ext_we, 1'b0);
        tick;
        ext_ready = 1'b1; ext_rdata = 32'h11111111;
        #1 check("simul_fetch_done", fetch_done, 1'b1);
        tick;
        idle_inputs;
        tick;

        // Data read with partial byte enables.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_be = 4'h3;
        tick;
        ext_ready = 1'b1; ext_rdata = 32'hCAFEF00D;
        #1 check("read_mem_done", mem_done, 1'b1);
        check("read_mem_rdata", mem_rdata, 32'hCAFEF00D);
        check("read_ext_be", ext_be, 4'h3);
        tick;
        idle_inputs;
        #1 check("read_mem_rdata_held", mem_rdata, 32'hCAFEF00D);
        tick;

        // Starvation: four data grants from idle, then fetch is forced ahead.
        fetch_req = 1'b1; fetch_addr = 32'h400; mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            mem_addr = 32'h500 + 32'(i * 4);
            tick;
            #1 check("starve_data_grant", ext_addr, 32'h500 + 32'(i * 4));
            ext_ready = 1'b1; ext_rdata = 32'(i); fetch_cancel = 1'b1;
            tick;
            ext_ready = 1'b0; fetch_cancel = 1'b0;
        end
        mem_addr = 32'h510;
        tick;
        #1 check("starve_fetch_forced", ext_addr, 32'h400);
        check("starve_fetch_we", ext_we, 1'b0);
        ext_ready = 1'b1; ext_rdata = 32'h0BADF00D;
        #1 check("starve_fetch_done", fetch_done, 1'b1);
        check("starve_mem_waits", mem_done, 1'b0);
        tick;
        fetch_req = 1'b0; ext_ready = 1'b0;
        #1 check("starve_data_after", ext_addr, 32'h510);
        ext_ready = 1'b1; ext_rdata = 32'h5;
        tick;
        idle_inputs;
        tick;

        // Cancel mid-flight: DRAIN in cycles 3-4, response discarded.
        fetch_req = 1'b1; fetch_addr = 32'h100;
        tick;
        tick;
        fetch_cancel = 1'b1;
        #1 check("cancel_no_done_c2", fetch_done, 1'b0);
        tick;
        fetch_cancel = 1'b0; fetch_req = 1'b0;
        #1 check("drain_ext_req", ext_req, 1'b1);
        check("drain_busy", busy, 1'b1);
        tick;
        ext_ready = 1'b1; ext_rdata = 32'h99999999;
        #1 check("drain_no_done", fetch_done, 1'b0);
        check("drain_rdata_kept", fetch_rdata, 32'h0BADF00D);
        tick;
        ext_ready = 1'b0;
        #1 check("drain_idle", busy, 1'b0);
        check("drain_rdata_still", fetch_rdata, 32'h0BADF00D);
        tick;

        // Cancel coincident with ready while data is pending.
        fetch_req = 1'b1; fetch_addr = 32'h108;
        tick;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600;
        ext_ready = 1'b1; ext_rdata = 32'h77; fetch_cancel = 1'b1;
        #1 check("coinc_no_fetch_done", fetch_done, 1'b0);
        check("coinc_mem_not_done", mem_done, 1'b0);
        tick;
        fetch_req = 1'b0; fetch_cancel = 1'b0;
        #1 check("coinc_data_addr", ext_addr, 32'h600);
        check("coinc_data_req", ext_req, 1'b1);
        ext_ready = 1'b1; ext_rdata = 32'h12345678;
        #1 check("coinc_mem_done", mem_done, 1'b1);
        check("coinc_mem_rdata", mem_rdata, 32'h12345678);
        tick;
        idle_inputs;
        tick;

        // Reset in cycle 2 of a data write, then normal re-grant.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h700; mem_wdata = 32'hA5A5A5A5; mem_be = 4'hF;
        tick;
        tick;
        #1 rst = 1'b1;
        #1 check("rst_mid_ext_req", ext_req, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ext_addr", ext_addr, 32'h0);
        tick;
        rst = 1'b0;
        #1 check("rst_release_idle", ext_req, 1'b0);
        tick;
        #1 check("rst_regrant_req", ext_req, 1'b1);
        check("rst_regrant_addr", ext_addr, 32'h700);
        check("rst_regrant_we", ext_we, 1'b1);
        ext_ready = 1'b1;
        #1 check("rst_regrant_done", mem_done, 1'b1);
        tick;
        idle_inputs;
        tick;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch stage and the memory-access stage of the 5-stage pipeline.
- Grants one requester at a time, holds the external request until the memory signals completion, and returns data to the granted port.
- Generates `fetch_done` and `mem_done` for the pipeline controller.
- Discards in-flight fetches cancelled by a taken branch; prevents fetch starvation.

Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced ahead (range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_req  in  1  fetch stage requests an instruction read
- fetch_addr  in  ADDR_WIDTH  fetch address
- fetch_cancel  in  1  taken branch; discard current or pending fetch
- fetch_rdata  out  DATA_WIDTH  instruction word, valid when fetch_done
- fetch_done  out  1  one-cycle completion pulse for fetch
- mem_req  in  1  memory stage requests an access
- mem_we  in  1  1 = write, 0 = read
- mem_be  in  DATA_WIDTH/8  byte enables
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  DATA_WIDTH  write data
- mem_rdata  out  DATA_WIDTH  read data, valid when mem_done and !mem_we
- mem_done  out  1  high when mem_req is low, or in the cycle the data access completes
- ext_req  out  1  external request, held until ext_ready
- ext_we  out  1  external write enable
- ext_be  out  DATA_WIDTH/8  external byte enables
- ext_addr  out  ADDR_WIDTH  external address
- ext_wdata  out  DATA_WIDTH  external write data
- ext_rdata  in  DATA_WIDTH  external read data, valid with ext_ready
- ext_ready  in  1  one-cycle completion from external memory
- busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE: no transaction.
  - FETCH: fetch transaction outstanding.
  - DATA: data transaction outstanding.
  - DRAIN: cancelled fetch outstanding; response is discarded.
- Reset (async, rst=1): state=IDLE, starve_cnt=0, ext_req=0, ext_we=0, ext_be=0, ext_addr=0, ext_wdata=0, fetch_done=0, fetch_rdata=0, mem_rdata=0. mem_done follows !mem_req.
- Arbitration runs in IDLE and in any cycle where ext_ready completes a transaction. Eligible requesters:
  - fetch: fetch_req && !fetch_cancel
  - data: mem_req
- Priority:
  - Data wins, unless fetch is eligible and starve_cnt == STARVE_LIMIT; then fetch wins.
  - A lone eligible requester always wins.
- Grant side effects:
  - Request fields are registered into the ext_* outputs.
  - ext_req=1 from the next cycle; next state is FETCH or DATA.
  - For fetch grants: ext_we=0, ext_be=all ones.
- starve_cnt:
  - +1 on each data grant while fetch_req && !fetch_cancel; saturates at STARVE_LIMIT.
  - Cleared on a fetch grant, or when fetch_req is low.
- Completion (ext_ready in FETCH or DATA):
  - fetch_done or mem_done is high combinationally that cycle.
  - The read data is driven to fetch_rdata or mem_rdata, and held until the next completion on that port.
  - The port just served is masked from arbitration that cycle, because its request still reflects the finished access.
  - The other port may be granted back-to-back; otherwise next state is IDLE and ext_req=0.
- Minimum latency: request in cycle 0, ext_req in cycle 1. If ext_ready arrives in cycle 1, done is in cycle 1.
- The requester holds its request and fields stable until done; the arbiter does not re-sample the address after grant.
- ext_ready in IDLE is ignored.
- fetch_cancel:
  - In FETCH without ext_ready: go to DRAIN. ext_req stays high until ext_ready; fetch_done is suppressed.
  - In FETCH with ext_ready in the same cycle: fetch_done is suppressed; arbitration proceeds.
  - In DRAIN: ext_ready suppresses output, then arbitration proceeds with fetch masked only if fetch_cancel is still high.
  - In IDLE or DATA: only masks fetch eligibility that cycle. Data transactions are never cancelled.
- Reset mid-transaction: the outstanding transaction is abandoned and ext_req drops immediately. External memory is reset by the same rst.

Decomposition:
- defines.v: state encodings (`ARB_IDLE`, `ARB_FETCH`, `ARB_DATA`, `ARB_DRAIN`, 2-bit `ARB_STATE_BUS`); reuse existing `ADDR_BUS`.
- One optional sub-module, mem_arb_starve_ctr: saturating counter with clear, for the starvation logic. The FSM and datapath stay in the top module.

Test Plan:
- Single fetch: fetch_req=1, addr=0x100; ext_ready in cycle 3 with ext_rdata=0x2402000A -> ext_req cycles 1-3, ext_addr=0x100, fetch_done pulse in cycle 3, fetch_rdata=0x2402000A.
- Simultaneous requests: fetch_req and mem_req (write 0x200, wdata 0xDEADBEEF, be=0xF) in cycle 0 -> data granted first with ext_we=1. Fetch is granted back-to-back in the data completion cycle; fetch ext_req starts in the following cycle.
- Starvation: mem_req held high, fetch_req high, STARVE_LIMIT=4 -> 4 data grants, then the 5th grant goes to fetch even though mem_req=1; starve_cnt returns to 0.
- Cancel mid-flight: fetch granted at 0x100, fetch_cancel in cycle 2, ext_ready in cycle 4 -> state DRAIN in cycles 3-4, no fetch_done pulse, fetch_rdata unchanged.
- Cancel coincident with ext_ready while mem_req is pending -> fetch_done=0 and data is granted in the same cycle.
- Reset mid-transaction: rst asserted in cycle 2 of a DATA access -> ext_req=0 asynchronously and busy=0. After release, the next mem_req is granted normally.
